// File: rtl/interp_sched.sv
// interp_sched: time-shares one interp plane-equation datapath across a triangle's per-vertex parameters.
// Define INTERP_SCHED_PERF_EN to add saturating busy-cycle and sample counters.
module interp_sched #(
  parameter int NUM_PARAMS = 8,
  parameter int INTERP_LAT = 1,
  localparam int PW = $clog2(NUM_PARAMS)
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          tri_valid_i,
  output logic          tri_ready_o,
  input  logic [7:0]    tri_frac_bits_i,
  input  logic [31:0]   tri_fx1_i,
  input  logic [31:0]   tri_fx2_i,
  input  logic [31:0]   tri_fx3_i,
  input  logic [31:0]   tri_fy1_i,
  input  logic [31:0]   tri_fy2_i,
  input  logic [31:0]   tri_fy3_i,
  input  logic [PW:0]   tri_nparams_i,
  input  logic          span_valid_i,
  output logic          span_ready_o,
  input  logic [10:0]   span_x_i,
  input  logic [10:0]   span_y_i,
  input  logic [10:0]   span_len_i,
  input  logic          span_last_i,
  output logic          prm_rd_o,
  output logic [PW-1:0] prm_idx_o,
  input  logic [31:0]   prm_fz1_i,
  input  logic [31:0]   prm_fz2_i,
  input  logic [31:0]   prm_fz3_i,
  output logic [7:0]    ip_frac_bits_o,
  output logic [31:0]   ip_fx1_o,
  output logic [31:0]   ip_fx2_o,
  output logic [31:0]   ip_fx3_o,
  output logic [31:0]   ip_fy1_o,
  output logic [31:0]   ip_fy2_o,
  output logic [31:0]   ip_fy3_o,
  output logic [31:0]   ip_fz1_o,
  output logic [31:0]   ip_fz2_o,
  output logic [31:0]   ip_fz3_o,
  output logic [10:0]   ip_x_o,
  output logic [10:0]   ip_y_o,
  input  logic [31:0]   ip_result_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [10:0]   out_x_o,
  output logic [10:0]   out_y_o,
  output logic [PW-1:0] out_idx_o,
  output logic [31:0]   out_value_o,
  output logic          out_last_o,
  output logic          busy_o
`ifdef INTERP_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_busy_cycles_o,
  output logic [31:0]   perf_samples_o
`endif
);

  localparam int NPW = PW + 1;
  localparam int CW  = $clog2(INTERP_LAT + 1);
  localparam logic [NPW-1:0] NP_MAX = NPW'(NUM_PARAMS);

  // state  | meaning
  // IDLE   | waiting for a triangle
  // SPAN   | triangle latched, waiting for a span
  // FETCH  | one-cycle parameter-store read for idx
  // WAIT   | capture vertex values, then wait out interp latency
  // EMIT   | sample presented on the out stream
  typedef enum logic [2:0] {S_IDLE, S_SPAN, S_FETCH, S_WAIT, S_EMIT} state_e;

  state_e state_q, state_d;

  logic [7:0]     frac_q;
  logic [31:0]    fx1_q, fx2_q, fx3_q, fy1_q, fy2_q, fy3_q;
  logic [31:0]    fz1_q, fz2_q, fz3_q;
  logic [NPW-1:0] np_q;
  logic [10:0]    x_q, y_q, rem_q;
  logic [PW-1:0]  idx_q;
  logic           last_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    value_q;

  logic tri_hs, span_hs, out_hs, span_empty, idx_more, pix_last;

  assign tri_hs     = (state_q == S_IDLE) && tri_valid_i;
  assign span_hs    = (state_q == S_SPAN) && span_valid_i;
  assign out_hs     = (state_q == S_EMIT) && out_ready_i;
  assign span_empty = (span_len_i == 11'd0) || (np_q == '0);
  assign idx_more   = (NPW'(idx_q) + NPW'(1)) < np_q;
  assign pix_last   = (rem_q == 11'd1);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tri_valid_i) state_d = S_SPAN;
      S_SPAN: begin
        if (span_valid_i) begin
          if (span_empty) state_d = span_last_i ? S_IDLE : S_SPAN;
          else            state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_EMIT;
      S_EMIT: begin
        if (out_ready_i) begin
          if (idx_more)      state_d = S_FETCH;
          else if (pix_last) state_d = last_q ? S_IDLE : S_SPAN;
          else               state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tri_ready_o  = 1'b0;
    span_ready_o = 1'b0;
    prm_rd_o     = 1'b0;
    out_valid_o  = 1'b0;
    out_last_o   = 1'b0;
    busy_o       = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        tri_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_SPAN:  span_ready_o = 1'b1;
      S_FETCH: prm_rd_o = 1'b1;
      S_WAIT:  ;
      S_EMIT: begin
        out_valid_o = 1'b1;
        out_last_o  = pix_last && !idx_more;
      end
      default: busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frac_q  <= '0;
      fx1_q   <= '0;
      fx2_q   <= '0;
      fx3_q   <= '0;
      fy1_q   <= '0;
      fy2_q   <= '0;
      fy3_q   <= '0;
      fz1_q   <= '0;
      fz2_q   <= '0;
      fz3_q   <= '0;
      np_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      if (tri_hs) begin
        frac_q <= tri_frac_bits_i;
        fx1_q  <= tri_fx1_i;
        fx2_q  <= tri_fx2_i;
        fx3_q  <= tri_fx3_i;
        fy1_q  <= tri_fy1_i;
        fy2_q  <= tri_fy2_i;
        fy3_q  <= tri_fy3_i;
        np_q   <= (tri_nparams_i > NP_MAX) ? NP_MAX : tri_nparams_i;
      end
      if (span_hs) begin
        x_q    <= span_x_i;
        y_q    <= span_y_i;
        rem_q  <= span_len_i;
        idx_q  <= '0;
        last_q <= span_last_i;
      end
      if (state_q == S_FETCH) cnt_q <= CW'(INTERP_LAT);
      // WAIT lasts INTERP_LAT+1 cycles: the first latches vertex values, the last captures the result
      if (state_q == S_WAIT) begin
        if (cnt_q == CW'(INTERP_LAT)) begin
          fz1_q <= prm_fz1_i;
          fz2_q <= prm_fz2_i;
          fz3_q <= prm_fz3_i;
        end
        if (cnt_q == '0) value_q <= ip_result_i;
        else             cnt_q   <= cnt_q - CW'(1);
      end
      if (out_hs) begin
        if (idx_more) begin
          idx_q <= idx_q + PW'(1);
        end else begin
          idx_q <= '0;
          x_q   <= x_q + 11'd1;
          rem_q <= rem_q - 11'd1;
        end
      end
    end
  end

  assign prm_idx_o      = idx_q;
  assign ip_frac_bits_o = frac_q;
  assign ip_fx1_o       = fx1_q;
  assign ip_fx2_o       = fx2_q;
  assign ip_fx3_o       = fx3_q;
  assign ip_fy1_o       = fy1_q;
  assign ip_fy2_o       = fy2_q;
  assign ip_fy3_o       = fy3_q;
  assign ip_fz1_o       = fz1_q;
  assign ip_fz2_o       = fz2_q;
  assign ip_fz3_o       = fz3_q;
  assign ip_x_o         = x_q;
  assign ip_y_o         = y_q;
  assign out_x_o        = x_q;
  assign out_y_o        = y_q;
  assign out_idx_o      = idx_q;
  assign out_value_o    = value_q;

`ifdef INTERP_SCHED_PERF_EN
  logic [31:0] perf_busy_q, perf_samples_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_busy_q    <= '0;
      perf_samples_q <= '0;
    end else begin
      if (busy_o && (perf_busy_q != 32'hFFFF_FFFF)) perf_busy_q <= perf_busy_q + 32'd1;
      if (out_hs && (perf_samples_q != 32'hFFFF_FFFF)) perf_samples_q <= perf_samples_q + 32'd1;
    end
  end

  assign perf_busy_cycles_o = perf_busy_q;
  assign perf_samples_o     = perf_samples_q;
`endif

endmodule

// File: tb/tb_interp_sched.sv
// Randomized bench for interp_sched: sample stream checked against a per-span expected-sample queue.
module tb_interp_sched;
  localparam int NP  = 8;
  localparam int LAT = 1;
  localparam int PW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          tri_valid_i, tri_ready_o;
  logic [7:0]    tri_frac_bits_i;
  logic [31:0]   tri_fx1_i, tri_fx2_i, tri_fx3_i, tri_fy1_i, tri_fy2_i, tri_fy3_i;
  logic [PW:0]   tri_nparams_i;
  logic          span_valid_i, span_ready_o;
  logic [10:0]   span_x_i, span_y_i, span_len_i;
  logic          span_last_i;
  logic          prm_rd_o;
  logic [PW-1:0] prm_idx_o;
  logic [31:0]   prm_fz1_i, prm_fz2_i, prm_fz3_i;
  logic [7:0]    ip_frac_bits_o;
  logic [31:0]   ip_fx1_o, ip_fx2_o, ip_fx3_o, ip_fy1_o, ip_fy2_o, ip_fy3_o;
  logic [31:0]   ip_fz1_o, ip_fz2_o, ip_fz3_o;
  logic [10:0]   ip_x_o, ip_y_o;
  logic [31:0]   ip_result_i;
  logic          out_valid_o, out_ready_i;
  logic [10:0]   out_x_o, out_y_o;
  logic [PW-1:0] out_idx_o;
  logic [31:0]   out_value_o;
  logic          out_last_o, busy_o;
`ifdef INTERP_SCHED_PERF_EN
  logic [31:0]   perf_busy_cycles_o, perf_samples_o;
`endif

  interp_sched #(.NUM_PARAMS(NP), .INTERP_LAT(LAT)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .tri_valid_i(tri_valid_i), .tri_ready_o(tri_ready_o), .tri_frac_bits_i(tri_frac_bits_i),
    .tri_fx1_i(tri_fx1_i), .tri_fx2_i(tri_fx2_i), .tri_fx3_i(tri_fx3_i),
    .tri_fy1_i(tri_fy1_i), .tri_fy2_i(tri_fy2_i), .tri_fy3_i(tri_fy3_i),
    .tri_nparams_i(tri_nparams_i),
    .span_valid_i(span_valid_i), .span_ready_o(span_ready_o),
    .span_x_i(span_x_i), .span_y_i(span_y_i), .span_len_i(span_len_i), .span_last_i(span_last_i),
    .prm_rd_o(prm_rd_o), .prm_idx_o(prm_idx_o),
    .prm_fz1_i(prm_fz1_i), .prm_fz2_i(prm_fz2_i), .prm_fz3_i(prm_fz3_i),
    .ip_frac_bits_o(ip_frac_bits_o),
    .ip_fx1_o(ip_fx1_o), .ip_fx2_o(ip_fx2_o), .ip_fx3_o(ip_fx3_o),
    .ip_fy1_o(ip_fy1_o), .ip_fy2_o(ip_fy2_o), .ip_fy3_o(ip_fy3_o),
    .ip_fz1_o(ip_fz1_o), .ip_fz2_o(ip_fz2_o), .ip_fz3_o(ip_fz3_o),
    .ip_x_o(ip_x_o), .ip_y_o(ip_y_o), .ip_result_i(ip_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_idx_o(out_idx_o),
    .out_value_o(out_value_o), .out_last_o(out_last_o), .busy_o(busy_o)
`ifdef INTERP_SCHED_PERF_EN
    , .perf_busy_cycles_o(perf_busy_cycles_o), .perf_samples_o(perf_samples_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // stub interp datapath: combinational, so valid within the single latency cycle
  function automatic logic [31:0] stub(input logic [31:0] f1, input logic [31:0] f2,
                                       input logic [31:0] f3, input logic [10:0] x,
                                       input logic [10:0] y);
    return f1 + {21'd0, x} + {21'd0, y} + (f2 ^ {f3[15:0], f3[31:16]});
  endfunction

  assign ip_result_i = stub(ip_fz1_o, ip_fz2_o, ip_fz3_o, ip_x_o, ip_y_o);

  // parameter store: vertex values appear the cycle after the read strobe
  logic [31:0] mem1 [NP];
  logic [31:0] mem2 [NP];
  logic [31:0] mem3 [NP];
  always @(posedge clk) begin
    if (prm_rd_o) begin
      prm_fz1_i <= mem1[prm_idx_o];
      prm_fz2_i <= mem2[prm_idx_o];
      prm_fz3_i <= mem3[prm_idx_o];
    end
  end

  int bench_busy = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bench_busy <= 0;
    else if (busy_o) bench_busy <= bench_busy + 1;
  end

  typedef struct {
    logic [10:0]   x;
    logic [10:0]   y;
    logic [PW-1:0] idx;
    logic [31:0]   v;
    logic          last;
  } smp_t;

  int t_np;

  task automatic send_tri(input int n);
    logic [31:0] fx [3];
    logic [31:0] fy [3];
    logic [7:0]  fr;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      fx[i] = $urandom;
      fy[i] = $urandom;
    end
    fr = 8'($urandom);
    for (int i = 0; i < NP; i++) begin
      mem1[i] = $urandom;
      mem2[i] = $urandom;
      mem3[i] = $urandom;
    end
    t_np = (n > NP) ? NP : n;
    tri_fx1_i = fx[0]; tri_fx2_i = fx[1]; tri_fx3_i = fx[2];
    tri_fy1_i = fy[0]; tri_fy2_i = fy[1]; tri_fy3_i = fy[2];
    tri_frac_bits_i = fr;
    tri_nparams_i = (PW+1)'(n);
    tri_valid_i = 1'b1;
    cyc = 0;
    while (!tri_ready_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check("tri_timeout", 64'(cyc), 64'(0));
    @(negedge clk);
    tri_valid_i = 1'b0;
    tri_fx1_i = '0; tri_fy1_i = '0; tri_frac_bits_i = '0;
    check("ip_frac", 64'(ip_frac_bits_o), 64'(fr));
    check("ip_fx1", 64'(ip_fx1_o), 64'(fx[0]));
    check("ip_fx2", 64'(ip_fx2_o), 64'(fx[1]));
    check("ip_fx3", 64'(ip_fx3_o), 64'(fx[2]));
    check("ip_fy1", 64'(ip_fy1_o), 64'(fy[0]));
    check("ip_fy2", 64'(ip_fy2_o), 64'(fy[1]));
    check("ip_fy3", 64'(ip_fy3_o), 64'(fy[2]));
    check("span_rdy_after_tri", 64'(span_ready_o), 64'(1));
  endtask

  // mode 0: out_ready always high, 1: stall 7 cycles on 2nd sample, 2: random out_ready
  task automatic run_span(input logic [10:0] x, input logic [10:0] y, input int len,
                          input logic last, input int mode);
    smp_t q[$];
    smp_t s;
    int cyc, first_rd, first_v, last_acc, stall_left, acc;
    logic rdy, hold;
    logic [10:0] hx;
    logic [PW-1:0] hidx;
    logic [31:0] hv;
    for (int p = 0; p < len; p++) begin
      for (int i = 0; i < t_np; i++) begin
        s.x    = 11'(int'(x) + p);
        s.y    = y;
        s.idx  = PW'(i);
        s.v    = stub(mem1[i], mem2[i], mem3[i], s.x, y);
        s.last = (p == len - 1) && (i == t_np - 1);
        q.push_back(s);
      end
    end
    span_x_i = x; span_y_i = y; span_len_i = 11'(len); span_last_i = last;
    span_valid_i = 1'b1;
    cyc = 0;
    while (!span_ready_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check("span_timeout", 64'(cyc), 64'(0));
    @(negedge clk);
    span_valid_i = 1'b0;
    if (q.size() == 0) begin
      check("empty_ovalid", 64'(out_valid_o), 64'(0));
      check("empty_next_rdy", 64'(last ? tri_ready_o : span_ready_o), 64'(1));
      return;
    end
    cyc = 0; first_rd = -1; first_v = -1; last_acc = -1; stall_left = 7; acc = 0;
    hold = 1'b0; hx = '0; hidx = '0; hv = '0;
    while (q.size() > 0 && cyc < 5000) begin
      if (hold) begin
        check("hold_valid", 64'(out_valid_o), 64'(1));
        check("hold_x", 64'(out_x_o), 64'(hx));
        check("hold_idx", 64'(out_idx_o), 64'(hidx));
        check("hold_value", 64'(out_value_o), 64'(hv));
        check("stall_prm_rd", 64'(prm_rd_o), 64'(0));
      end
      if (prm_rd_o && first_rd < 0) first_rd = cyc;
      if (out_valid_o && first_v < 0) first_v = cyc;
      rdy = 1'b1;
      if (mode == 1 && acc == 1 && out_valid_o && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
      out_ready_i = rdy;
      hold = out_valid_o && !rdy;
      hx = out_x_o; hidx = out_idx_o; hv = out_value_o;
      if (out_valid_o && rdy) begin
        s = q.pop_front();
        check("out_x", 64'(out_x_o), 64'(s.x));
        check("out_y", 64'(out_y_o), 64'(s.y));
        check("out_idx", 64'(out_idx_o), 64'(s.idx));
        check("out_value", 64'(out_value_o), 64'(s.v));
        check("out_last", 64'(out_last_o), 64'(s.last));
        if (mode == 0 && last_acc >= 0) check("interval", 64'(cyc - last_acc), 64'(3 + LAT));
        last_acc = cyc;
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    if (q.size() > 0) check("samples_timeout", 64'(q.size()), 64'(0));
    check("after_ovalid", 64'(out_valid_o), 64'(0));
    check("after_next_rdy", 64'(last ? tri_ready_o : span_ready_o), 64'(1));
    if (mode == 0) check("first_latency", 64'(first_v - first_rd), 64'(2 + LAT));
  endtask

  initial begin
    int nsp, n;
    logic [10:0] rx;
    rst_n = 1'b0;
    tri_valid_i = 0; tri_frac_bits_i = 0; tri_nparams_i = 0;
    tri_fx1_i = 0; tri_fx2_i = 0; tri_fx3_i = 0; tri_fy1_i = 0; tri_fy2_i = 0; tri_fy3_i = 0;
    span_valid_i = 0; span_x_i = 0; span_y_i = 0; span_len_i = 0; span_last_i = 0;
    prm_fz1_i = 0; prm_fz2_i = 0; prm_fz3_i = 0; out_ready_i = 0;
    repeat (3) @(negedge clk);
    check("rst_tri_ready", 64'(tri_ready_o), 64'(1));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_span_ready", 64'(span_ready_o), 64'(0));
    check("rst_prm_rd", 64'(prm_rd_o), 64'(0));
    check("rst_ip_fx1", 64'(ip_fx1_o), 64'(0));
    check("rst_ip_fz1", 64'(ip_fz1_o), 64'(0));
    check("rst_ip_xy", 64'({ip_x_o, ip_y_o}), 64'(0));
    check("rst_out_value", 64'(out_value_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    send_tri(3);
    run_span(11'd10, 11'd5, 2, 1'b1, 0);
`ifdef INTERP_SCHED_PERF_EN
    check("perf_samples", 64'(perf_samples_o), 64'(6));
    check("perf_busy", 64'(perf_busy_cycles_o), 64'(bench_busy));
`endif

    send_tri(3);
    run_span(11'd20, 11'd7, 3, 1'b1, 1);

    send_tri(2);
    run_span(11'd2046, 11'd9, 3, 1'b0, 0);
    run_span(11'd50, 11'd1, 0, 1'b0, 0);
    run_span(11'd60, 11'd2, 1, 1'b1, 2);

    send_tri(12);
    run_span(11'd3, 11'd3, 1, 1'b1, 0);
    send_tri(0);
    run_span(11'd5, 11'd5, 2, 1'b1, 0);

    // asynchronous reset while a sample is in flight
    send_tri(2);
    span_x_i = 11'd100; span_y_i = 11'd4; span_len_i = 11'd3; span_last_i = 1'b1;
    span_valid_i = 1'b1;
    @(negedge clk);
    span_valid_i = 1'b0;
    @(negedge clk);
    check("midwait_busy", 64'(busy_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midwait_rst_busy", 64'(busy_o), 64'(0));
    check("midwait_rst_tri_ready", 64'(tri_ready_o), 64'(1));
    check("midwait_rst_out_valid", 64'(out_valid_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid_o), 64'(0));
    check("post_rst_tri_ready", 64'(tri_ready_o), 64'(1));

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(0, 15);
      send_tri(n);
      nsp = $urandom_range(1, 3);
      for (int s = 0; s < nsp; s++) begin
        rx = ($urandom_range(0, 3) == 0) ? 11'(2045 + $urandom_range(0, 2)) : 11'($urandom);
        run_span(rx, 11'($urandom), $urandom_range(0, 3), s == nsp - 1, 2);
      end
    end

`ifdef INTERP_SCHED_PERF_EN
    force dut.perf_samples_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.perf_samples_q;
    send_tri(2);
    run_span(11'd30, 11'd30, 1, 1'b1, 0);
    check("perf_saturate", 64'(perf_samples_o), 64'(32'hFFFF_FFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
